// File: rtl/button_event.sv
// button_event
//   Turns the debounced push-button level into one-cycle event pulses for the
//   egg-timer controller. It produces a press pulse, a release pulse, and an
//   auto-repeating step stream while the button is held. This lets a held
//   button scroll the set value.
//
// Parameters
//   HOLD_CYCLES   : cycles btn must stay high after the press before hold (>= 2)
//   REPEAT_CYCLES : cycles between auto-repeat steps while holding (>= 2)
//   CNT_W         : counter width, must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1
//
// Ports
//   clk_i      : system clock, rising edge
//   rst_ni     : synchronous reset, active low
//   btn_i      : debounced, already-synchronous button level (1 = pressed)
//   press_o    : one-cycle pulse on press
//   release_o  : one-cycle pulse on release
//   step_o     : one-cycle pulse on press and on each auto-repeat
//   hold_o     : high while the button is in the hold phase
//   step_cnt_o : steps issued since the last press, saturating at 255
module button_event #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  output logic       press_o,
  output logic       release_o,
  output logic       step_o,
  output logic       hold_o,
  output logic [7:0] step_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  logic             hold_q, hold_d;
  logic [7:0]       step_cnt_q, step_cnt_d;

  // The step count sticks at 255 while step keeps pulsing.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    step_d     = 1'b0;
    step_cnt_d = step_cnt_q;

    case (state_q)
      IDLE: begin
        if (btn_i) begin
          state_d    = PRESSED;
          cnt_d      = '0;
          press_d    = 1'b1;
          step_d     = 1'b1;
          step_cnt_d = 8'd1;
        end
      end

      // Release is tested first so it wins over a terminal count.
      PRESSED: begin
        if (!btn_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d    = HOLD;
          cnt_d      = '0;
          step_d     = 1'b1;
          step_cnt_d = sat_inc(step_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD: begin
        if (!btn_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d      = '0;
          step_d     = 1'b1;
          step_cnt_d = sat_inc(step_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // hold is a registered copy of "next state is HOLD", so it rises with the
    // first hold step and falls together with the release pulse.
    hold_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      step_q     <= 1'b0;
      hold_q     <= 1'b0;
      step_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign press_o    = press_q;
  assign release_o  = release_q;
  assign step_o     = step_q;
  assign hold_o     = hold_q;
  assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       press, rel, step, hold;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;

  // Event counters observed on the DUT, cleared by the stimulus per scenario.
  int n_press = 0, n_release = 0, n_step = 0, n_hold = 0;

  button_event #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_i     (btn),
    .press_o   (press),
    .release_o (rel),
    .step_o    (step),
    .hold_o    (hold),
    .step_cnt_o(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: time since the press decides everything.
  int   cyc = 0;
  int   k = 0;
  bit   active = 0;
  bit   started = 0;
  bit   e_press = 0, e_release = 0, e_step = 0, e_hold = 0;
  int   e_cnt = 0;

  always @(posedge clk) begin
    int d;
    e_press = 0; e_release = 0; e_step = 0;
    if (!rst_n) begin
      active = 0; e_hold = 0; e_cnt = 0;
    end else if (!active) begin
      e_hold = 0;
      if (btn) begin
        active = 1; k = cyc;
        e_press = 1; e_step = 1; e_cnt = 1;
      end
    end else if (!btn) begin
      active = 0; e_release = 1; e_hold = 0;
    end else begin
      d = cyc - k;
      if (d >= HOLD) begin
        e_hold = 1;
        if ((d - HOLD) % REP == 0) begin
          e_step = 1;
          if (e_cnt < 255) e_cnt++;
        end
      end
    end
    cyc++;
    started = 1;
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      check("press",    int'(press),    int'(e_press));
      check("release",  int'(rel),      int'(e_release));
      check("step",     int'(step),     int'(e_step));
      check("hold",     int'(hold),     int'(e_hold));
      check("step_cnt", int'(step_cnt), e_cnt);
      if (press === 1'b1) n_press++;
      if (rel === 1'b1)   n_release++;
      if (step === 1'b1)  n_step++;
      if (hold === 1'b1)  n_hold++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    n_press = 0; n_release = 0; n_step = 0; n_hold = 0;
  endtask

  initial begin
    // Reset with btn high: nothing happens until reset lifts.
    btn = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_press", int'(press), 0);
    check("rst_step_cnt", int'(step_cnt), 0);
    check("rst_hold", int'(hold), 0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_press", int'(press), 1);
    check("post_rst_step_cnt", int'(step_cnt), 1);
    btn = 1'b0;
    tick(1);
    check("post_rst_release", int'(rel), 1);
    tick(3);

    // Short tap: three cycles high.
    clr();
    btn = 1'b1; tick(3);
    btn = 1'b0; tick(1);
    check("tap_release_now", int'(rel), 1);
    tick(3);
    check("tap_n_press", n_press, 1);
    check("tap_n_step", n_step, 1);
    check("tap_n_release", n_release, 1);
    check("tap_n_hold", n_hold, 0);
    check("tap_step_cnt", int'(step_cnt), 1);

    // Hold and repeat: thirty cycles high.
    clr();
    btn = 1'b1; tick(30);
    btn = 1'b0; tick(3);
    check("hr_n_step", n_step, 7);
    check("hr_n_hold", n_hold, 22);
    check("hr_n_release", n_release, 1);
    check("hr_step_cnt", int'(step_cnt), 7);

    // Release exactly at the hold boundary.
    clr();
    btn = 1'b1; tick(8);
    btn = 1'b0; tick(1);
    check("bnd_release", int'(rel), 1);
    check("bnd_hold", int'(hold), 0);
    check("bnd_step", int'(step), 0);
    tick(2);
    check("bnd_n_step", n_step, 1);
    check("bnd_n_hold", n_hold, 0);

    // Saturation: 1 press step + 1 hold step + 300 repeats.
    clr();
    btn = 1'b1; tick(HOLD + REP * 300 + 1);
    check("sat_step_cnt", int'(step_cnt), 255);
    check("sat_n_step", n_step, 302);
    btn = 1'b0; tick(2);
    check("sat_after_release", int'(step_cnt), 255);

    // Reset in the middle of hold, btn kept high.
    clr();
    btn = 1'b1; tick(15);
    check("mid_hold_level", int'(hold), 1);
    rst_n = 1'b0; tick(1);
    check("mid_rst_hold", int'(hold), 0);
    check("mid_rst_release", int'(rel), 0);
    check("mid_rst_step_cnt", int'(step_cnt), 0);
    rst_n = 1'b1; tick(1);
    check("mid_repress", int'(press), 1);
    btn = 1'b0; tick(2);
    check("mid_n_release", n_release, 1);
    check("mid_n_press", n_press, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced push-button level from the egg-timer's debounce stage into one-cycle event pulses for the timer controller: press, release, and an auto-repeating step stream while the button is held. It sits directly downstream of the debouncer and upstream of the minute/second set logic. It lets a held button scroll the set value without firmware or extra counters in the controller.

## Interface
Parameters:
- HOLD_CYCLES, default 50_000_000: cycles btn must stay high after the press before hold begins; must be >= 2.
- REPEAT_CYCLES, default 12_500_000: cycles between auto-repeat steps while in hold; must be >= 2.
- CNT_W, default 26: cycle-counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- btn  in  1  debounced, already-synchronous button level (1 = pressed).
- press  out  1  one-cycle pulse on press.
- release  out  1  one-cycle pulse on release.
- step  out  1  one-cycle pulse on press and on each auto-repeat.
- hold  out  1  level; high while in HOLD state.
- step_cnt  out  8  steps issued since the last press, saturating at 255.

## Operation
- States: IDLE, PRESSED, HOLD. Single counter cnt (CNT_W bits). All outputs are registered.
- Reset (rst=0 at a clock edge): state=IDLE, cnt=0, press=release=step=hold=0, step_cnt=0. Reset overrides every transition, including mid-hold; no release pulse is generated by reset.
- IDLE:
  - btn=1: go to PRESSED, cnt=0, assert press=1 and step=1 for one cycle, step_cnt=1.
  - btn=0: stay in IDLE.
- PRESSED:
  - btn=0: go to IDLE, release=1 for one cycle.
  - btn=1 and cnt==HOLD_CYCLES-1: go to HOLD, cnt=0, hold=1, step=1, step_cnt+1.
  - btn=1 otherwise: cnt+1.
- HOLD:
  - btn=0: go to IDLE, release=1 for one cycle, hold=0.
  - btn=1 and cnt==REPEAT_CYCLES-1: cnt=0, step=1, step_cnt+1.
  - btn=1 otherwise: cnt+1.
- Pulse outputs default to 0 every cycle unless a rule above asserts them.
- step_cnt:
  - Saturates: it stays at 255 once reached, while step keeps pulsing.
  - It holds its value in IDLE until the next press reloads it to 1.
- Release has priority over the terminal count. If btn=0 at the edge where cnt would reach its terminal value, no step or hold occurs.
- press and release are never high in the same cycle. A one-cycle btn high produces press/step followed by release on the next cycle.

## Timing
- Latency: btn first sampled high at edge k gives press=step=1 in the cycle following edge k. Likewise, btn first sampled low at edge m gives release=1 (and hold=0) in the cycle following edge m.
- First hold step and hold rising edge occur in the cycle after edge k+HOLD_CYCLES.
- Repeat step n (n>=1) occurs in the cycle after edge k+HOLD_CYCLES+n*REPEAT_CYCLES.
- Minimum re-press spacing: btn low for one sampled cycle returns to IDLE. The next high sample produces a new press.
- There is no internal synchronizer or filtering; btn must already be synchronous to clk.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Reset: hold rst=0 for 3 cycles with btn=1, then release reset. All outputs are 0 during reset. A press pulse occurs in the cycle after the first edge with rst=1 and btn=1.
- Short tap: btn high for 3 cycles from edge 10, then low.
  - press=step=1 after edge 10 only.
  - release=1 after edge 13.
  - hold never asserts; step_cnt=1.
- Hold and repeat: btn high from edge 10 for 30 cycles.
  - step pulses after edges 10, 18, 22, 26, 30, 34, 38.
  - hold is high from after edge 18 until after edge 40, when release=1.
  - step_cnt=7.
- Boundary release: btn high at edges 10..17, low at edge 18. release=1 after edge 18; no hold and no second step.
- Saturation: hold btn for 8+4*300 cycles. step_cnt reaches 255 and stays there while step continues pulsing every 4 cycles.
- Reset mid-hold: assert rst=0 at edge 25 during hold. All outputs are 0 after edge 25, no release pulse, state IDLE. If btn is still high after reset deasserts, press=1 occurs on the next edge.
